combination_sender: RTL and testbench
=====================================

# combination_sender

Drives the two button-press inputs (`zero`, `one`) of the combination lock, the transmitting end of the lock's button interface. On `start` it latches a code word and plays it out MSB-first as clean, timed, mutually exclusive pulses. After the last press it watches the lock's `unlocked` output for a bounded window and reports pass/fail. It sits between test/control logic and the lock, and is the block the team uses to exercise and operate the lock in clocked systems.

## Interface
- `MAX_LEN`, 8: maximum code length in bits.
- `PULSE_CYCLES`, 2: cycles each press is held high (≥1).
- `GAP_CYCLES`, 2: cycles both lines are low after each press (≥1).
- `TIMEOUT`, 4: cycles `unlocked` is watched after the final gap (≥1).

- `clk` input 1: single clock; all state updates on rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `start` input 1: begin a transmission; sampled only in IDLE.
- `abort` input 1: cancel any transmission in progress.
- `code_len` input clog2(MAX_LEN+1): number of bits to send; valid range 1..MAX_LEN.
- `code_bits` input MAX_LEN: code word; bit `code_len-1` is sent first, bit 0 last.
- `unlocked` input 1: lock's unlocked output.
- `zero` output 1: press of the 0 button.
- `one` output 1: press of the 1 button.
- `busy` output 1: transmission or check in progress.
- `done` output 1: one-cycle completion strobe.
- `pass` output 1: result of the check; valid while `done`=1, then holds until the next `start`.
- `err` output 1: one-cycle strobe when `start` is rejected.
- `state` output 3: numeric encoding of the current state.

## Operation
- States: IDLE=0, PULSE=1, GAP=2, WAIT=3, DONE=4.
- IDLE:
  - `start`=1 with valid `code_len`: latch `code_bits` and `code_len`, clear `pass`, go to PULSE.
  - `start`=1 with `code_len`=0 or >MAX_LEN: pulse `err`, stay in IDLE.
- PULSE: drive exactly one of `zero`/`one` according to the current bit, for PULSE_CYCLES cycles, then go to GAP.
- GAP: drive both lines low for GAP_CYCLES cycles.
  - Bits remaining: advance to the next bit and go to PULSE.
  - Otherwise: go to WAIT.
- WAIT: sample `unlocked` each cycle, for up to TIMEOUT cycles.
  - First cycle `unlocked`=1: set `pass`=1, go to DONE.
  - Timeout expires: go to DONE with `pass`=0.
- DONE: one cycle; `done`=1; then go to IDLE.
- `abort`=1 in any non-IDLE state: go to IDLE on the next edge, drive both lines low, and do not assert `done`. `abort` takes priority over every other transition. `abort` in IDLE has no effect.
- `start` outside IDLE is ignored: no `err`, no re-latch.
- Input changes to `code_bits`/`code_len` after the latch have no effect.

## Timing
- All outputs are registered. Reset values: `zero`=`one`=`busy`=`done`=`pass`=`err`=0, `state`=0.
- Asserting `rst_n`=0 mid-transmission immediately forces both lines low and the state to IDLE.
- Cycle N is the edge on which `start` is sampled.
- From N+1:
  - First press occupies cycles N+1..N+PULSE_CYCLES.
  - Each subsequent bit starts PULSE_CYCLES+GAP_CYCLES cycles after the previous one.
- Final gap ends at N + code_len·(PULSE_CYCLES+GAP_CYCLES).
- WAIT lasts 1..TIMEOUT cycles.
- `busy`=1 from N+1 through the DONE cycle inclusive.
- Next `start` is accepted the cycle after DONE.
- `zero` and `one` are never high together and never high in two consecutive presses without a gap.
- `err` is asserted at N+1 for one cycle.

## Structure
- Shared package `comb_lock_pkg` holds:
  - state encoding constants (IDLE..DONE);
  - default code constant 5'b01011 and its length 5, shared with the lock's test environment.
- One natural sub-module, `press_timer`: a loadable down-counter with a zero flag. It serves PULSE, GAP, and WAIT durations; width is clog2(max(PULSE_CYCLES, GAP_CYCLES, TIMEOUT)+1).
- The bit index counter and shift of the latched code stay in the top module.

## Test plan
- Default parameters, `code_len`=5, `code_bits`=0x0B, lock model attached, `start` at cycle 0:
  - `zero` high in cycles 1–2, `one` high in 5–6, `zero` in 9–10, `one` in 13–14 and 17–18.
  - Lock unlocks, so `done`=1 with `pass`=1 in the cycle after `unlocked` is first seen.
- Same code, with `unlocked` tied 0: WAIT runs 4 cycles, then `done`=1 with `pass`=0 at cycle 25.
- `code_len`=0 and `code_len`=9 at `start`: `err`=1 for one cycle, `busy` stays 0, no presses.
- `abort` at cycle 7 mid-transmission:
  - Cycle 8: state 0, both lines low.
  - `done` never asserts.
  - A new `start` at cycle 10 is accepted.
- `rst_n` low at cycle 6 during a press: all outputs 0 immediately; after release, idle until `start`.
- `start` pulsed at cycles 3 and 12 during a transmission, with different `code_bits`: both ignored, and the original code is sent unchanged.

Source files
------------

// File: rtl/comb_lock_pkg.sv
// Shared definitions for the combination lock and its button-press sender.
// State encoding, the default code word, and a small sizing helper.
package comb_lock_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PULSE = 3'd1,
    ST_GAP   = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [4:0]  DEFAULT_CODE = 5'b01011;
  localparam int unsigned DEFAULT_LEN  = 5;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/combination_sender_press_timer.sv
// Loadable down-counter with a registered zero flag; times press, gap and
// unlock-watch durations for combination_sender.
module press_timer #(
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_zero
);

  logic [W-1:0] r_count;
  logic         r_zero;

  // Count down to zero; the flag is registered so it lines up with the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_zero  <= 1'b1;
    end else if (i_load) begin
      r_count <= i_load_val;
      r_zero  <= (i_load_val == '0);
    end else if (r_count != '0) begin
      r_count <= r_count - W'(1);
      r_zero  <= (r_count == W'(1));
    end else begin
      r_zero  <= 1'b1;
    end
  end

  assign o_zero = r_zero;

endmodule

// File: rtl/combination_sender.sv
// Plays a latched code word MSB-first onto the lock's zero/one buttons as
// timed, exclusive pulses, then watches the unlocked line and reports pass/fail.
module combination_sender
  import comb_lock_pkg::*;
#(
  parameter int unsigned MAX_LEN      = 8,
  parameter int unsigned PULSE_CYCLES = 2,
  parameter int unsigned GAP_CYCLES   = 2,
  parameter int unsigned TIMEOUT      = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic                           abort,
  input  logic [$clog2(MAX_LEN+1)-1:0]   code_len,
  input  logic [MAX_LEN-1:0]             code_bits,
  input  logic                           unlocked,
  output logic                           zero,
  output logic                           one,
  output logic                           busy,
  output logic                           done,
  output logic                           pass,
  output logic                           err,
  output logic [2:0]                     state
);

  localparam int unsigned LW = $clog2(MAX_LEN + 1);
  localparam int unsigned TW = $clog2(max3(PULSE_CYCLES, GAP_CYCLES, TIMEOUT) + 1);
  localparam logic [TW-1:0] PULSE_LD = TW'(PULSE_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LD   = TW'(GAP_CYCLES - 1);
  localparam logic [TW-1:0] WAIT_LD  = TW'(TIMEOUT - 1);

  state_t             r_state;
  logic               r_zero, r_one, r_busy, r_done, r_pass, r_err;
  logic [MAX_LEN-1:0] r_shift;
  logic [LW-1:0]      r_left;

  logic               w_len_ok;
  logic               w_tmr_zero;
  logic               w_load;
  logic [TW-1:0]      w_load_val;
  logic [MAX_LEN-1:0] w_aligned;
  logic [MAX_LEN-1:0] w_shift_next;

  // Left-align the code so the bit to send is always the shift register MSB.
  assign w_len_ok     = (code_len != '0) && (code_len <= LW'(MAX_LEN));
  assign w_aligned    = code_bits << (LW'(MAX_LEN) - code_len);
  assign w_shift_next = {r_shift[MAX_LEN-2:0], 1'b0};

  // Timer reload on every phase entry, in step with the state register.
  always_comb begin
    w_load     = 1'b0;
    w_load_val = PULSE_LD;
    case (r_state)
      ST_IDLE: begin
        w_load     = start && w_len_ok;
        w_load_val = PULSE_LD;
      end
      ST_PULSE: begin
        w_load     = w_tmr_zero;
        w_load_val = GAP_LD;
      end
      ST_GAP: begin
        w_load = w_tmr_zero;
        if (r_left > LW'(1)) begin
          w_load_val = PULSE_LD;
        end else begin
          w_load_val = WAIT_LD;
        end
      end
      default: begin
        w_load     = 1'b0;
        w_load_val = PULSE_LD;
      end
    endcase
  end

  press_timer #(.W(TW)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_zero     (w_tmr_zero)
  );

  // Sequencer: state, registered button lines and status strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_zero  <= 1'b0;
      r_one   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
      r_err   <= 1'b0;
      r_shift <= '0;
      r_left  <= '0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      if (abort && (r_state != ST_IDLE)) begin
        r_state <= ST_IDLE;
        r_zero  <= 1'b0;
        r_one   <= 1'b0;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (start && w_len_ok) begin
              r_state <= ST_PULSE;
              r_shift <= w_aligned;
              r_left  <= code_len;
              r_pass  <= 1'b0;
              r_busy  <= 1'b1;
              r_one   <= w_aligned[MAX_LEN-1];
              r_zero  <= ~w_aligned[MAX_LEN-1];
            end else if (start) begin
              r_err <= 1'b1;
            end
          end
          ST_PULSE: begin
            if (w_tmr_zero) begin
              r_state <= ST_GAP;
              r_zero  <= 1'b0;
              r_one   <= 1'b0;
            end
          end
          ST_GAP: begin
            if (w_tmr_zero && (r_left > LW'(1))) begin
              r_state <= ST_PULSE;
              r_left  <= r_left - LW'(1);
              r_shift <= w_shift_next;
              r_one   <= w_shift_next[MAX_LEN-1];
              r_zero  <= ~w_shift_next[MAX_LEN-1];
            end else if (w_tmr_zero) begin
              r_state <= ST_WAIT;
            end
          end
          ST_WAIT: begin
            if (unlocked) begin
              r_state <= ST_DONE;
              r_pass  <= 1'b1;
              r_done  <= 1'b1;
            end else if (w_tmr_zero) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end
          end
          ST_DONE: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
          default: begin
            r_state <= ST_IDLE;
            r_zero  <= 1'b0;
            r_one   <= 1'b0;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign zero  = r_zero;
  assign one   = r_one;
  assign busy  = r_busy;
  assign done  = r_done;
  assign pass  = r_pass;
  assign err   = r_err;
  assign state = r_state;

endmodule

// File: tb/tb_combination_sender.sv
// Bench for combination_sender: directed scenarios with literal timelines plus
// a randomized run, all checked every cycle against a timeline-based model.
module tb_combination_sender;
  import comb_lock_pkg::*;

  localparam int MAX_LEN = 8;
  localparam int P       = 2;
  localparam int G       = 2;
  localparam int TO      = 4;
  localparam int PER     = P + G;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [3:0] code_len = 4'd0;
  logic [7:0] code_bits = 8'd0;
  logic       unlocked;
  logic       zero, one, busy, done, pass, err;
  logic [2:0] state;

  int n_chk = 0;
  int n_err = 0;

  // lock model and unlocked source selection
  logic       lock_en = 1'b0;
  logic       lock_clr = 1'b0;
  logic       tie_unl = 1'b0;
  logic [4:0] lk_hist = 5'd0;
  logic       lk_prev = 1'b0;
  logic       lk_unl = 1'b0;

  assign unlocked = lock_en ? lk_unl : tie_unl;

  combination_sender #(
    .MAX_LEN(MAX_LEN), .PULSE_CYCLES(P), .GAP_CYCLES(G), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .code_len(code_len), .code_bits(code_bits), .unlocked(unlocked),
    .zero(zero), .one(one), .busy(busy), .done(done), .pass(pass),
    .err(err), .state(state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (lock_clr) begin
      lk_hist <= 5'd0;
      lk_prev <= 1'b0;
      lk_unl  <= 1'b0;
    end else begin
      lk_prev <= zero | one;
      if ((zero | one) && !lk_prev) lk_hist <= {lk_hist[3:0], one};
      lk_unl <= (lk_hist == DEFAULT_CODE);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Reference model: position in the transaction timeline decides the outputs.
  int         m_act = 0, m_t = 0, m_len = 0, m_done_at = 0;
  logic       m_hold = 1'b0, m_err = 1'b0;
  logic [7:0] m_code = 8'd0;

  always @(negedge clk) begin
    int   tt, k, r;
    logic e_zero, e_one, e_busy, e_done;
    logic [2:0] e_state;
    if (!rst_n) begin
      m_act = 0; m_hold = 1'b0; m_err = 1'b0;
    end else begin
      e_zero = 1'b0; e_one = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_state = 3'd0;
      tt = m_len * PER;
      if (m_act != 0) begin
        e_busy = 1'b1;
        if (m_t <= tt) begin
          k = (m_t - 1) / PER;
          r = (m_t - 1) % PER;
          if (r < P) begin
            e_one   = m_code[m_len - 1 - k];
            e_zero  = ~e_one;
            e_state = 3'd1;
          end else begin
            e_state = 3'd2;
          end
        end else if (m_t == m_done_at) begin
          e_state = 3'd4;
          e_done  = 1'b1;
        end else begin
          e_state = 3'd3;
        end
      end
      chk("zero",  32'(zero),  32'(e_zero));
      chk("one",   32'(one),   32'(e_one));
      chk("busy",  32'(busy),  32'(e_busy));
      chk("done",  32'(done),  32'(e_done));
      chk("pass",  32'(pass),  32'(m_hold));
      chk("err",   32'(err),   32'(m_err));
      chk("state", 32'(state), 32'(e_state));
      // advance the model by the edge that follows
      m_err = 1'b0;
      if (m_act != 0) begin
        if (abort) begin
          m_act = 0;
        end else if (m_t == m_done_at) begin
          m_act = 0;
        end else begin
          if (m_t > tt) begin
            if (unlocked) begin
              m_done_at = m_t + 1; m_hold = 1'b1;
            end else if (m_t - tt == TO) begin
              m_done_at = m_t + 1; m_hold = 1'b0;
            end
          end
          m_t++;
        end
      end else if (start) begin
        if (code_len >= 4'd1 && code_len <= 4'd8) begin
          m_act = 1; m_t = 1; m_len = int'(code_len); m_code = code_bits;
          m_done_at = 0; m_hold = 1'b0;
        end else begin
          m_err = 1'b1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  logic [31:0] vz, vo, vd, vp, vb, ve;
  logic [2:0]  st8;

  // Runs ncyc cycles after a start already set up; t is the cycle index.
  task automatic run(input int ncyc, input int alt_a, input int alt_b,
                     input int abort_at, input int restart_at, input int rst_at);
    vz = 32'd0; vo = 32'd0; vd = 32'd0; vp = 32'd0; vb = 32'd0; ve = 32'd0;
    st8 = 3'd7;
    for (int t = 1; t <= ncyc; t++) begin
      tick();
      if (t < 32) begin
        vz[t] = zero; vo[t] = one; vd[t] = done; vp[t] = pass; vb[t] = busy; ve[t] = err;
      end
      if (t == 8) st8 = state;
      start = (t == alt_a) || (t == alt_b) || (t == restart_at);
      if (t == alt_a || t == alt_b) begin
        code_bits = 8'hF4; code_len = 4'd7;
      end
      if (t == restart_at) begin
        code_bits = 8'(DEFAULT_CODE); code_len = 4'(DEFAULT_LEN);
      end
      abort = (t == abort_at);
      if (t == rst_at) begin
        chk("one_before_rst", 32'(one), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("outs_in_rst", 32'({zero, one, busy, done, pass, err, state}), 32'd0);
      end
      if (rst_at > 0 && t == rst_at + 3) rst_n = 1'b1;
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic go_default();
    code_len  = 4'(DEFAULT_LEN);
    code_bits = 8'(DEFAULT_CODE);
    start     = 1'b1;
  endtask

  initial begin
    repeat (3) tick();
    chk("reset_outs", 32'({zero, one, busy, done, pass, err, state}), 32'd0);
    rst_n = 1'b1;
    tick();

    // lock attached: unlock seen in first WAIT cycle 21, done at 22
    lock_clr = 1'b1; tick(); lock_clr = 1'b0; lock_en = 1'b1;
    go_default();
    run(30, -1, -1, -1, -1, -1);
    chk("A_zero_vec", vz, 32'h0000_0606);
    chk("A_one_vec",  vo, 32'h0006_6060);
    chk("A_done_vec", vd, 32'h0040_0000);
    chk("A_pass22",   32'(vp[22]), 32'd1);
    chk("A_busy_vec", vb, 32'h007F_FFFE);

    // unlocked tied low, stray starts at 3 and 12 with another code
    lock_en = 1'b0; tie_unl = 1'b0;
    go_default();
    run(30, 3, 12, -1, -1, -1);
    chk("B_zero_vec", vz, 32'h0000_0606);
    chk("B_one_vec",  vo, 32'h0006_6060);
    chk("B_done_vec", vd, 32'h0200_0000);
    chk("B_pass25",   32'(vp[25]), 32'd0);
    chk("B_busy_vec", vb, 32'h03FF_FFFE);

    // rejected lengths
    code_len = 4'd0; start = 1'b1;
    run(4, -1, -1, -1, -1, -1);
    chk("C0_err_vec", ve, 32'h2);
    chk("C0_busy",    vb, 32'h0);
    chk("C0_press",   vz | vo, 32'h0);
    code_len = 4'd9; start = 1'b1;
    run(4, -1, -1, -1, -1, -1);
    chk("C9_err_vec", ve, 32'h2);
    chk("C9_busy",    vb, 32'h0);
    chk("C9_press",   vz | vo, 32'h0);

    // abort at 7, restart at 10
    go_default();
    run(45, -1, -1, 7, 10, -1);
    chk("D_state8",  32'(st8), 32'd0);
    chk("D_lines8",  32'({vz[8], vo[8]}), 32'd0);
    chk("D_no_done", vd & 32'h0000_07FE, 32'h0);
    chk("D_busy",    vb & 32'h0000_0FFE, 32'h0000_08FE);

    // reset during the press in cycle 6
    go_default();
    run(16, -1, -1, -1, -1, 6);
    chk("E_idle_after", vb & 32'h0001_FC00, 32'h0);

    // randomized traffic
    for (int i = 0; i < 2500; i++) begin
      tick();
      start     = ($urandom_range(0, 4) == 0);
      code_len  = 4'($urandom_range(0, 10));
      code_bits = 8'($urandom);
      abort     = ($urandom_range(0, 50) == 0);
      tie_unl   = ($urandom_range(0, 5) == 0);
    end
    start = 1'b0; abort = 1'b0;
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
